// File: rtl/aes_pkg.sv
// Shared AES key-schedule types, per-key-length lookups, GF(2^8) doubling and the S-box table.
// Pure declarations: no state, no flow control.
package aes_pkg;

  typedef enum logic [1:0] {
    KEY_128  = 2'd0,
    KEY_192  = 2'd1,
    KEY_256  = 2'd2,
    KEY_RSVD = 2'd3
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [3:0] nk_of(key_len_e kl);
    case (kl)
      KEY_128: return 4'd4;
      KEY_192: return 4'd6;
      KEY_256: return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(key_len_e kl);
    case (kl)
      KEY_128: return 4'd10;
      KEY_192: return 4'd12;
      KEY_256: return 4'd14;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_subword.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
// Zero latency, no flow control.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  assign dout = {SBOX[din[31:24]], SBOX[din[23:16]], SBOX[din[15:8]], SBOX[din[7:0]]};

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-128/192/256 key expander: one schedule word per cycle into a round-key store.
// Expansion takes 40/46/52 busy cycles; start ignored unless idle; reads answer one cycle after rd_en.
module aes_key_schedule_seq
  import aes_pkg::*;
#(
  parameter int NK_MAX   = 8,
  parameter int NR_MAX   = 14,
  parameter int RD_IDX_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            key_len,
  input  logic [32*NK_MAX-1:0]  key_in,
  output logic                  busy,
  output logic                  ready,
  output logic                  done,
  output logic                  cfg_err,
  output logic [3:0]            nr,
  input  logic                  rd_en,
  input  logic [RD_IDX_W-1:0]   rd_idx,
  output logic                  rd_valid,
  output logic                  rd_err,
  output logic [127:0]          rd_key
);

  localparam int DEPTH  = 4 * (NR_MAX + 1);
  localparam int WIDX_W = $clog2(DEPTH);

  state_e state, state_nxt;

  logic [DEPTH-1:0][31:0] store;
  logic [WIDX_W-1:0]      widx;
  logic [WIDX_W-1:0]      last_idx;
  logic [3:0]             wrap;
  logic [3:0]             nk_q;
  logic [7:0]             rcon;
  logic                   ready_q;
  logic                   cfg_err_q;

  key_len_e          kl;
  logic              start_ok;
  logic              gen_we;
  logic [3:0]        nk_sel;
  logic [3:0]        nr_sel;
  logic [WIDX_W-1:0] idx_prev;
  logic [WIDX_W-1:0] idx_back;
  logic [31:0]       w_prev;
  logic [31:0]       w_back;
  logic [31:0]       sub_in;
  logic [31:0]       sub_out;
  logic [31:0]       temp;
  logic [31:0]       w_new;

  assign kl       = key_len_e'(key_len);
  assign nk_sel   = nk_of(kl);
  assign nr_sel   = nr_of(kl);
  assign start_ok = (state == ST_IDLE) && start && (kl != KEY_RSVD);
  assign gen_we   = (state == ST_GEN);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_ok) state_nxt = ST_GEN;
      ST_GEN:  if (widx == last_idx) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state == ST_GEN);
    done = (state == ST_DONE);
  end

  assign ready   = ready_q;
  assign cfg_err = cfg_err_q;
  assign nr      = nk_q == 4'd0 ? 4'd0 : nk_q + 4'd6;

  // i mod Nk comes from the wrap counter, so no divider is needed.
  assign idx_prev = widx - WIDX_W'(1);
  assign idx_back = widx - WIDX_W'(nk_q);
  assign w_prev   = store[idx_prev];
  assign w_back   = store[idx_back];

  always_comb begin
    sub_in = (wrap == 4'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    temp   = w_prev;
    if (wrap == 4'd0)                        temp = sub_out ^ {rcon, 24'h0};
    else if (nk_q == 4'd8 && wrap == 4'd4)  temp = sub_out;
  end

  assign w_new = w_back ^ temp;

  aes_subword u_subword (
    .din  (sub_in),
    .dout (sub_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      widx      <= '0;
      last_idx  <= '0;
      wrap      <= '0;
      nk_q      <= '0;
      rcon      <= 8'h01;
      ready_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= (state == ST_IDLE) && start && (kl == KEY_RSVD);
      if (start_ok) begin
        nk_q     <= nk_sel;
        last_idx <= WIDX_W'({nr_sel, 2'b11});
        widx     <= WIDX_W'(nk_sel);
        wrap     <= '0;
        rcon     <= 8'h01;
        ready_q  <= 1'b0;
      end else if (gen_we) begin
        widx <= widx + WIDX_W'(1);
        wrap <= (wrap == nk_q - 4'd1) ? 4'd0 : wrap + 4'd1;
        if (wrap == 4'd0) rcon <= xtime(rcon);
        if (widx == last_idx) ready_q <= 1'b1;
      end
    end
  end

  // Store is not reset: ready gates every read of it.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      for (int k = 0; k < NK_MAX; k++) begin
        if (4'(k) < nk_sel) store[k] <= key_in[32*NK_MAX-1-32*k -: 32];
      end
    end else if (gen_we) begin
      store[widx] <= w_new;
    end
  end

  logic [RD_IDX_W-1:0] rd_sel;
  logic [WIDX_W-1:0]   rd_base;
  logic                rd_bad;

  assign rd_bad  = !ready_q || (rd_idx > nr);
  assign rd_sel  = (rd_idx > RD_IDX_W'(NR_MAX)) ? '0 : rd_idx;
  assign rd_base = WIDX_W'({rd_sel, 2'b00});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_key   <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en && rd_bad;
      if (rd_en) begin
        if (rd_bad) rd_key <= '0;
        else        rd_key <= {store[rd_base], store[rd_base + WIDX_W'(1)],
                               store[rd_base + WIDX_W'(2)], store[rd_base + WIDX_W'(3)]};
      end
    end
  end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Bench for aes_key_schedule_seq: FIPS-197 vectors plus random keys against a reference
// expansion built from an S-box derived from GF(2^8) inversion and the affine map.
module tb_aes_key_schedule_seq;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         busy, ready, done, cfg_err;
  logic [3:0]   nr;
  logic         rd_en;
  logic [3:0]   rd_idx;
  logic         rd_valid, rd_err;
  logic [127:0] rd_key;

  int total;
  int bad;

  logic [7:0]  sref [256];
  logic [31:0] mw [60];
  int          m_nr;
  int          m_nk;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_schedule_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_len  (key_len),
    .key_in   (key_in),
    .busy     (busy),
    .ready    (ready),
    .done     (done),
    .cfg_err  (cfg_err),
    .nr       (nr),
    .rd_en    (rd_en),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_err   (rd_err),
    .rd_key   (rd_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int n = 0; n < 8; n++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int s);
    logic [15:0] d;
    d = {b, b} << s;
    return d[15:8];
  endfunction

  task automatic build_sbox;
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sref[v[31:24]], sref[v[23:16]], sref[v[15:8]], sref[v[7:0]]};
  endfunction

  // Straight FIPS-197 KeyExpansion over the whole word array.
  task automatic model_expand(input logic [255:0] key, input int len);
    logic [31:0] t;
    logic [7:0]  rc;
    int          tot;
    m_nk = 4 + 2 * len;
    m_nr = m_nk + 6;
    tot  = 4 * (m_nr + 1);
    rc   = 8'h01;
    for (int i = 0; i < m_nk; i++) mw[i] = key[255-32*i -: 32];
    for (int i = m_nk; i < tot; i++) begin
      t = mw[i-1];
      if (i % m_nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (m_nk == 8 && i % m_nk == 4) begin
        t = sub_word(t);
      end
      mw[i] = mw[i-m_nk] ^ t;
    end
  endtask

  function automatic logic [127:0] rk(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int n = 0; n < 8; n++) v[32*n +: 32] = $urandom;
    return v;
  endfunction

  // Keys get random junk in the unused LSBs so that "ignored" is actually exercised.
  function automatic logic [255:0] with_junk(input logic [255:0] key, input int len);
    logic [255:0] j;
    j = rnd256();
    if (len == 0) return {key[255:128], j[127:0]};
    if (len == 1) return {key[255:64], j[63:0]};
    return key;
  endfunction

  // Called at a falling edge; returns at the falling edge right after E0.
  task automatic kick(input logic [255:0] key, input int len);
    start = 1'b1; key_len = 2'(len); key_in = with_junk(key, len);
    @(negedge clk);
    start = 1'b0; key_in = rnd256();
  endtask

  task automatic wait_done(output int bcnt, output bit ok);
    bcnt = 0; ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (done === 1'b1) begin ok = 1'b1; break; end
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
    end
  endtask

  task automatic do_read(input int idx, output logic [127:0] k, output logic v, output logic e);
    rd_en = 1'b1; rd_idx = 4'(idx);
    @(negedge clk);
    v = rd_valid; e = rd_err; k = rd_key;
    rd_en = 1'b0;
  endtask

  task automatic test_reset;
    logic [127:0] k; logic v, e;
    rst_n = 1'b0; start = 1'b0; key_len = 2'd0; key_in = '0; rd_en = 1'b0; rd_idx = '0;
    #12;
    total++;
    if ({busy, ready, done, cfg_err, rd_valid, rd_err, nr, rd_key} !== '0) begin
      bad++; $display("FAIL reset_outputs got busy=%b ready=%b done=%b cfg_err=%b rd_valid=%b rd_err=%b nr=%0d rd_key=%h want all zero",
                      busy, ready, done, cfg_err, rd_valid, rd_err, nr, rd_key);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    do_read(0, k, v, e);
    total++;
    if ({v, e, k} !== {1'b1, 1'b1, 128'h0}) begin
      bad++; $display("FAIL read_before_ready got v=%b e=%b key=%h want v=1 e=1 key=0", v, e, k);
    end
  endtask

  task automatic test_aes128;
    logic [127:0] k; logic v, e; int bc; bit ok;
    model_expand(K128, 0);
    kick(K128, 0);
    wait_done(bc, ok);
    total++;
    if (!ok || bc != 40) begin bad++; $display("FAIL aes128_busy got=%0d done_seen=%0d want=40", bc, ok); end
    total++;
    if ({ready, busy, nr} !== {1'b1, 1'b0, 4'd10}) begin
      bad++; $display("FAIL aes128_done_state got ready=%b busy=%b nr=%0d want ready=1 busy=0 nr=10", ready, busy, nr);
    end
    @(negedge clk);
    total++;
    if ({done, ready} !== 2'b01) begin bad++; $display("FAIL aes128_done_pulse got done=%b ready=%b want done=0 ready=1", done, ready); end
    do_read(1, k, v, e);
    total++;
    if ({v, e, k} !== {1'b1, 1'b0, 128'ha0fafe1788542cb123a339392a6c7605}) begin
      bad++; $display("FAIL aes128_rk1 got v=%b e=%b key=%h want a0fafe1788542cb123a339392a6c7605", v, e, k);
    end
    do_read(10, k, v, e);
    total++;
    if ({v, e, k} !== {1'b1, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6}) begin
      bad++; $display("FAIL aes128_rk10 got v=%b e=%b key=%h want d014f9a8c9ee2589e13f0cc8b6630ca6", v, e, k);
    end
  endtask

  task automatic test_back_to_back;
    rd_en = 1'b1; rd_idx = 4'd10;
    for (int r = 10; r >= 0; r--) begin
      @(negedge clk);
      total++;
      if ({rd_valid, rd_err, rd_key} !== {1'b1, 1'b0, rk(r)}) begin
        bad++; $display("FAIL sweep_rk%0d got v=%b e=%b key=%h want %h", r, rd_valid, rd_err, rd_key, rk(r));
      end
      if (r > 0) rd_idx = 4'(r - 1);
      else       rd_en = 1'b0;
    end
    @(negedge clk);
    total++;
    if (rd_valid !== 1'b0) begin bad++; $display("FAIL sweep_valid_drop got=%b want=0", rd_valid); end
  endtask

  task automatic test_bad_idx;
    logic [127:0] k; logic v, e;
    for (int idx = 11; idx < 16; idx += 4) begin
      do_read(idx, k, v, e);
      total++;
      if ({v, e, k} !== {1'b1, 1'b1, 128'h0}) begin
        bad++; $display("FAIL bad_idx%0d got v=%b e=%b key=%h want v=1 e=1 key=0", idx, v, e, k);
      end
    end
  endtask

  task automatic test_cfg_err;
    start = 1'b1; key_len = 2'd3; key_in = rnd256();
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({cfg_err, busy, ready} !== 3'b101) begin
      bad++; $display("FAIL cfg_err_pulse got cfg_err=%b busy=%b ready=%b want 1 0 1", cfg_err, busy, ready);
    end
    @(negedge clk);
    total++;
    if ({cfg_err, busy, ready, nr} !== {3'b001, 4'd10}) begin
      bad++; $display("FAIL cfg_err_after got cfg_err=%b busy=%b ready=%b nr=%0d want 0 0 1 10", cfg_err, busy, ready, nr);
    end
  endtask

  task automatic test_aes192;
    logic [127:0] k; logic v, e; int bc; bit ok;
    kick(K192, 1);
    wait_done(bc, ok);
    total++;
    if (!ok || bc != 46 || nr !== 4'd12) begin bad++; $display("FAIL aes192_busy got=%0d done_seen=%0d nr=%0d want=46 nr=12", bc, ok, nr); end
    do_read(12, k, v, e);
    total++;
    if ({v, e, k} !== {1'b1, 1'b0, 128'he98ba06f448c773c8ecc720401002202}) begin
      bad++; $display("FAIL aes192_rk12 got v=%b e=%b key=%h want e98ba06f448c773c8ecc720401002202", v, e, k);
    end
  endtask

  task automatic test_aes256;
    logic [127:0] k; logic v, e; int bc; bit ok;
    kick(K256, 2);
    wait_done(bc, ok);
    total++;
    if (!ok || bc != 52 || nr !== 4'd14) begin bad++; $display("FAIL aes256_busy got=%0d done_seen=%0d nr=%0d want=52 nr=14", bc, ok, nr); end
    do_read(14, k, v, e);
    total++;
    if ({v, e, k} !== {1'b1, 1'b0, 128'hfe4890d1e6188d0b046df344706c631e}) begin
      bad++; $display("FAIL aes256_rk14 got v=%b e=%b key=%h want fe4890d1e6188d0b046df344706c631e", v, e, k);
    end
  endtask

  task automatic test_start_mid_gen;
    logic [255:0] ka; logic [127:0] k; logic v, e; int bc; bit ok;
    ka = rnd256();
    model_expand(ka, 1);
    kick(ka, 1);
    repeat (10) @(negedge clk);
    start = 1'b1; key_len = 2'd2; key_in = rnd256();
    @(negedge clk);
    start = 1'b0;
    wait_done(bc, ok);
    total++;
    if (!ok || bc != 46 - 11 || nr !== 4'd12) begin
      bad++; $display("FAIL midgen_done got busy_tail=%0d done_seen=%0d nr=%0d want tail=35 nr=12", bc, ok, nr);
    end
    for (int r = 0; r <= 12; r++) begin
      do_read(r, k, v, e);
      total++;
      if ({v, e, k} !== {1'b1, 1'b0, rk(r)}) begin
        bad++; $display("FAIL midgen_rk%0d got v=%b e=%b key=%h want %h", r, v, e, k, rk(r));
      end
    end
  endtask

  task automatic test_restart;
    logic [255:0] kn; logic [127:0] k; logic v, e; int bc; bit ok;
    kn = rnd256();
    model_expand(kn, 0);
    kick(kn, 0);
    total++;
    if ({ready, busy} !== 2'b01) begin bad++; $display("FAIL restart_e0 got ready=%b busy=%b want ready=0 busy=1", ready, busy); end
    wait_done(bc, ok);
    total++;
    if (!ok || bc != 40 || nr !== 4'd10) begin bad++; $display("FAIL restart_busy got=%0d done_seen=%0d nr=%0d want=40 nr=10", bc, ok, nr); end
    for (int r = 0; r <= 10; r++) begin
      do_read(r, k, v, e);
      total++;
      if ({v, e, k} !== {1'b1, 1'b0, rk(r)}) begin
        bad++; $display("FAIL restart_rk%0d got v=%b e=%b key=%h want %h", r, v, e, k, rk(r));
      end
    end
  endtask

  task automatic test_reset_mid_gen;
    logic [127:0] k; logic v, e;
    kick(rnd256(), 2);
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, ready, done, cfg_err, rd_valid, rd_err, nr, rd_key} !== '0) begin
      bad++; $display("FAIL midgen_reset got busy=%b ready=%b done=%b nr=%0d rd_key=%h want all zero", busy, ready, done, nr, rd_key);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, ready, done} !== 3'b000) begin bad++; $display("FAIL midgen_reset_idle got busy=%b ready=%b done=%b want 0 0 0", busy, ready, done); end
    do_read(0, k, v, e);
    total++;
    if ({v, e, k} !== {1'b1, 1'b1, 128'h0}) begin
      bad++; $display("FAIL midgen_reset_read got v=%b e=%b key=%h want v=1 e=1 key=0", v, e, k);
    end
  endtask

  task automatic test_random;
    logic [255:0] key; logic [127:0] k; logic v, e; int bc, len; bit ok;
    for (int it = 0; it < 6; it++) begin
      key = rnd256();
      len = int'($urandom_range(0, 2));
      model_expand(key, len);
      kick(key, len);
      wait_done(bc, ok);
      total++;
      if (!ok || bc != 4 * (m_nr + 1) - m_nk || nr !== 4'(m_nr)) begin
        bad++; $display("FAIL rand%0d_busy got=%0d done_seen=%0d nr=%0d want=%0d nr=%0d", it, bc, ok, nr, 4 * (m_nr + 1) - m_nk, m_nr);
      end
      for (int r = m_nr + 1; r >= 0; r--) begin
        do_read(r, k, v, e);
        total++;
        if (r > m_nr) begin
          if ({v, e, k} !== {1'b1, 1'b1, 128'h0}) begin
            bad++; $display("FAIL rand%0d_over got v=%b e=%b key=%h want err", it, v, e, k);
          end
        end else if ({v, e, k} !== {1'b1, 1'b0, rk(r)}) begin
          bad++; $display("FAIL rand%0d_rk%0d got v=%b e=%b key=%h want %h", it, r, v, e, k, rk(r));
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    build_sbox();
    test_reset();
    test_aes128();
    test_back_to_back();
    test_bad_idx();
    test_cfg_err();
    test_aes192();
    test_aes256();
    test_start_mid_gen();
    test_restart();
    test_reset_mid_gen();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule_seq.md
Name: aes_key_schedule_seq

Overview:
- Parametrised, iterative AES key expander; successor to the fixed AES-128 whole-key expander.
- Supports 128-, 192- and 256-bit keys, selected per operation.
- Generates one 32-bit schedule word per cycle into an internal round-key store.
- The cipher and inverse-cipher datapaths read round keys by index, so forward and reverse (decrypt) order both work from one expansion.

Parameters:
- NK_MAX, 8: maximum key length in 32-bit words (8 = AES-256); key_in width = 32*NK_MAX.
- NR_MAX, 14: maximum round count; store depth = 4*(NR_MAX+1) words.
- RD_IDX_W, 4: width of the round-key read index.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request expansion; sampled only in IDLE
- key_len  in  2  0=AES-128, 1=AES-192, 2=AES-256, 3=reserved
- key_in  in  32*NK_MAX  cipher key, FIPS-197 byte order, left-aligned; byte 0 = key_in[MSB -: 8]; unused LSBs ignored
- busy  out  1  expansion in progress
- ready  out  1  store holds a complete valid schedule
- done  out  1  one-cycle pulse when expansion completes
- cfg_err  out  1  one-cycle pulse: start with key_len=3
- nr  out  4  round count of the stored schedule (10/12/14)
- rd_en  in  1  round-key read request
- rd_idx  in  RD_IDX_W  round number 0..nr
- rd_valid  out  1  read response valid, one cycle after rd_en
- rd_err  out  1  qualifies rd_valid: read while !ready or rd_idx>nr
- rd_key  out  128  round key = w[4*idx]..w[4*idx+3], w[4*idx] in MSBs

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE.
  - busy, ready, done, cfg_err, rd_valid, rd_err = 0.
  - nr = 0, rd_key = 0, word counter = 0, rcon = 8'h01.
  - Store contents need not be cleared.
- FSM states: IDLE, GEN, DONE.
- IDLE:
  - start=1 with key_len=3: pulse cfg_err; stay IDLE; ready unchanged.
  - start=1 with valid key_len, at edge E0:
    - Nk = 4/6/8, nr = 10/12/14, total = 4*(nr+1) = 44/52/60.
    - w[0..Nk-1] = key words; i = Nk; rcon = 01.
    - ready = 0, busy = 1; go to GEN.
- GEN: each edge writes w[i] = w[i-Nk] ^ temp, where temp is:
  - i mod Nk == 0: SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0}; then rcon = xtime(rcon), i.e. 01,02,04,...,80,1b,36.
  - Nk == 8 and i mod 8 == 4: SubWord(w[i-1]).
  - otherwise: w[i-1].
  - i increments each cycle; i mod Nk is tracked by a separate wrap counter (no divider).
  - When i == total-1 the write happens and the FSM goes to DONE.
- Latency: total-Nk GEN edges after E0, i.e. 40/46/52 cycles. busy is high for exactly that many cycles.
- DONE: lasts one cycle. done = 1, busy = 0, ready = 1; then back to IDLE.
- start is ignored while busy (no queue, no error).
- A new start in IDLE while ready=1 re-expands: ready drops at E0 and the old schedule is lost.
- Reads:
  - rd_en sampled each edge; the next cycle rd_valid = 1 for exactly one cycle.
  - Data path is registered: rd_key is from store words 4*idx..4*idx+3.
  - If !ready or rd_idx > nr: rd_err = 1 and rd_key = 0.
  - Reads during GEN always return rd_err (ready = 0).
  - Back-to-back reads supported: one per cycle.
- Reset mid-GEN: immediate abort to IDLE with ready = 0; a fresh start is required.

Decomposition:
- Package aes_pkg:
  - key_len_e enum.
  - NK/NR lookup functions of key_len.
  - xtime function.
  - Shared 256-entry S-box constant table.
- Sub-module aes_subword: 32-bit combinational SubWord, four S-box lookups. It is the only instance of S-box logic in this block.
- The store is a register array; no handshake with other blocks beyond the ports above.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c -> busy for 40 cycles, then done pulse; rd_idx=1 gives a0fafe1788542cb123a339392a6c7605; rd_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; nr=10.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> 46 busy cycles; rd_idx=12 gives e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> 52 busy cycles; rd_idx=14 gives fe4890d1e6188d0b046df344706c631e (exercises the i mod 8 == 4 SubWord path).
- Reverse read sweep 10..0 after the AES-128 expansion -> 11 consecutive rd_valid with no rd_err; rd_idx=11 gives rd_err=1, rd_key=0; key_len=3 gives a cfg_err pulse and busy stays 0.
- start re-asserted mid-GEN -> ignored, result still matches the first key.
- rst_n low at cycle 20 of GEN -> all outputs 0 immediately; read after release gives rd_err=1.
- New start after ready -> ready falls at E0 and the new key's schedule replaces the old one.
